// File: rtl/vx_execute_gather_if.sv
// Execute-bus bundle: partial-lane packets in, one gathered full-warp packet out.
// Latency: none, signal container only.
// Backpressure: in_ready flows back to the issuer, out_ready flows into the gatherer.
interface vx_execute_gather_if #(
    parameter int NUM_THREADS = 4,
    parameter int NUM_LANES   = 1,
    parameter int PID_WIDTH   = ((NUM_THREADS / NUM_LANES) > 1) ? $clog2(NUM_THREADS / NUM_LANES) : 1,
    parameter int XLEN        = 32,
    parameter int UUID_WIDTH  = 1,
    parameter int NW_WIDTH    = 2,
    parameter int NR_BITS     = 5
);
    // partial-lane execute packet
    logic                          in_valid;
    logic [UUID_WIDTH-1:0]         in_uuid;
    logic [NW_WIDTH-1:0]           in_wid;
    logic [NUM_LANES-1:0]          in_tmask;
    logic                          in_wb;
    logic [NR_BITS-1:0]            in_rd;
    logic [PID_WIDTH-1:0]          in_pid;
    logic                          in_sop;
    logic                          in_eop;
    logic [NUM_LANES*XLEN-1:0]     in_rs1_data;
    logic                          in_ready;

    // gathered full-warp packet
    logic                          out_valid;
    logic [UUID_WIDTH-1:0]         out_uuid;
    logic [NW_WIDTH-1:0]           out_wid;
    logic                          out_wb;
    logic [NR_BITS-1:0]            out_rd;
    logic [NUM_THREADS-1:0]        out_tmask;
    logic [NUM_THREADS*XLEN-1:0]   out_data;
    logic                          out_ready;

    // issuer side: drives packets, consumes the gathered warp
    modport master (
        output in_valid, in_uuid, in_wid, in_tmask, in_wb, in_rd,
               in_pid, in_sop, in_eop, in_rs1_data,
        input  in_ready,
        input  out_valid, out_uuid, out_wid, out_wb, out_rd, out_tmask, out_data,
        output out_ready
    );

    // gatherer side
    modport slave (
        input  in_valid, in_uuid, in_wid, in_tmask, in_wb, in_rd,
               in_pid, in_sop, in_eop, in_rs1_data,
        output in_ready,
        output out_valid, out_uuid, out_wid, out_wb, out_rd, out_tmask, out_data,
        input  out_ready
    );
endinterface

// File: rtl/vx_execute_gather.sv
// Reassembles pid/sop/eop-sequenced partial-lane packets into one full-warp packet.
// Latency: out_valid rises 1 cycle after the eop packet is accepted.
// Backpressure: in_ready drops only while a full warp is held and out_ready is low.
module vx_execute_gather #(
    parameter int NUM_THREADS = 4,
    parameter int NUM_LANES   = 1,
    parameter int PID_WIDTH   = ((NUM_THREADS / NUM_LANES) > 1) ? $clog2(NUM_THREADS / NUM_LANES) : 1,
    parameter int XLEN        = 32,
    parameter int UUID_WIDTH  = 1,
    parameter int NW_WIDTH    = 2,
    parameter int NR_BITS     = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    vx_execute_gather_if.slave   bus,
    output logic                 err_pulse
);
    localparam int NUM_PKTS = NUM_THREADS / NUM_LANES;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FULL    = 2'd2
    } state_t;

    state_t                        state;
    logic                          valid_q;
    logic                          err_q;
    logic [UUID_WIDTH-1:0]         uuid_q;
    logic [NW_WIDTH-1:0]           wid_q;
    logic                          wb_q;
    logic [NR_BITS-1:0]            rd_q;
    logic [NUM_THREADS-1:0]        tmask_q;
    logic [NUM_THREADS*XLEN-1:0]   data_q;

    logic                          accept;
    logic [NUM_THREADS-1:0]        merged_tmask;
    logic [NUM_THREADS*XLEN-1:0]   merged_data;

    // A held warp can drain and be replaced by a new sop in the same cycle.
    assign bus.in_ready = (state != FULL) | bus.out_ready;
    assign accept       = bus.in_valid & bus.in_ready;

    // Merge the incoming packet's lanes into the warp buffer; a sop starts from an empty mask.
    always_comb begin
        merged_tmask = bus.in_sop ? '0 : tmask_q;
        merged_data  = data_q;
        for (int p = 0; p < NUM_PKTS; p++) begin
            if (bus.in_pid == PID_WIDTH'(p)) begin
                merged_tmask[p*NUM_LANES +: NUM_LANES]      = bus.in_tmask;
                merged_data[p*NUM_LANES*XLEN +: NUM_LANES*XLEN] = bus.in_rs1_data;
            end
        end
    end

    // Gather FSM: header latched on sop, lanes merged on every legal packet, warp held until drained.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            tmask_q <= '0;
        end else begin
            err_q <= 1'b0;
            if (accept) begin
                if (bus.in_sop) begin
                    // a sop while collecting abandons the partial warp
                    if (state == COLLECT) begin
                        err_q <= 1'b1;
                    end
                    uuid_q  <= bus.in_uuid;
                    wid_q   <= bus.in_wid;
                    wb_q    <= bus.in_wb;
                    rd_q    <= bus.in_rd;
                    tmask_q <= merged_tmask;
                    data_q  <= merged_data;
                    state   <= bus.in_eop ? FULL : COLLECT;
                    valid_q <= bus.in_eop;
                end else if (state == COLLECT) begin
                    tmask_q <= merged_tmask;
                    data_q  <= merged_data;
                    if (bus.in_eop) begin
                        state   <= FULL;
                        valid_q <= 1'b1;
                    end
                end else begin
                    // orphan non-sop packet (IDLE, or FULL while draining): drop it
                    err_q   <= 1'b1;
                    state   <= IDLE;
                    valid_q <= 1'b0;
                end
            end else if ((state == FULL) && bus.out_ready) begin
                state   <= IDLE;
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_uuid  = uuid_q;
    assign bus.out_wid   = wid_q;
    assign bus.out_wb    = wb_q;
    assign bus.out_rd    = rd_q;
    assign bus.out_tmask = tmask_q;
    assign bus.out_data  = data_q;
    assign err_pulse     = err_q;
endmodule

// File: tb/tb_vx_execute_gather.sv
// Directed bench for the warp gatherer (4 threads, 1 lane per packet).
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: out_ready toggled explicitly by the stimulus sequence.
module tb_vx_execute_gather;
    localparam int NT = 4;
    localparam int NL = 1;
    localparam int PW = 2;
    localparam int XL = 32;

    logic clk;
    logic reset;
    logic err_pulse;
    int   tests;
    int   fails;

    vx_execute_gather_if #(.NUM_THREADS(NT), .NUM_LANES(NL), .PID_WIDTH(PW), .XLEN(XL),
                           .UUID_WIDTH(1), .NW_WIDTH(2), .NR_BITS(5)) bus ();

    vx_execute_gather #(.NUM_THREADS(NT), .NUM_LANES(NL), .PID_WIDTH(PW), .XLEN(XL),
                        .UUID_WIDTH(1), .NW_WIDTH(2), .NR_BITS(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .err_pulse (err_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int pid, input logic sop, input logic eop,
                         input logic tm, input logic [31:0] dat, input logic uid);
        bus.in_valid    = 1'b1;
        bus.in_pid      = PW'(pid);
        bus.in_sop      = sop;
        bus.in_eop      = eop;
        bus.in_tmask    = tm;
        bus.in_rs1_data = dat;
        bus.in_uuid     = uid;
        bus.in_wid      = 2'd2;
        bus.in_wb       = 1'b1;
        bus.in_rd       = 5'd7;
    endtask

    task automatic send(input int pid, input logic sop, input logic eop,
                        input logic tm, input logic [31:0] dat, input logic uid);
        drive(pid, sop, eop, tm, dat, uid);
        tick();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        bus.out_ready = 1'b0;
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        bus.in_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // reset state
        check("rst_out_valid", 128'(bus.out_valid), 128'd0);
        check("rst_err",       128'(err_pulse),     128'd0);
        check("rst_tmask",     128'(bus.out_tmask), 128'd0);
        check("rst_in_ready",  128'(bus.in_ready),  128'd1);

        // 1: full warp, downstream always ready
        bus.out_ready = 1'b1;
        send(0, 1'b1, 1'b0, 1'b1, 32'h10, 1'b0);
        check("t1_no_early_valid", 128'(bus.out_valid), 128'd0);
        send(1, 1'b0, 1'b0, 1'b1, 32'h11, 1'b0);
        send(2, 1'b0, 1'b0, 1'b1, 32'h12, 1'b0);
        send(3, 1'b0, 1'b1, 1'b1, 32'h13, 1'b0);
        check("t1_valid", 128'(bus.out_valid), 128'd1);
        check("t1_tmask", 128'(bus.out_tmask), 128'hF);
        check("t1_data",  128'(bus.out_data),  {32'h13, 32'h12, 32'h11, 32'h10});
        check("t1_wid",   128'(bus.out_wid),   128'd2);
        check("t1_rd",    128'(bus.out_rd),    128'd7);
        tick();
        check("t1_drained", 128'(bus.out_valid), 128'd0);

        // 2: stall with next sop waiting, then drain and refill with no bubble
        bus.out_ready = 1'b0;
        send(0, 1'b1, 1'b0, 1'b1, 32'h10, 1'b0);
        send(1, 1'b0, 1'b0, 1'b1, 32'h11, 1'b0);
        send(2, 1'b0, 1'b0, 1'b1, 32'h12, 1'b0);
        send(3, 1'b0, 1'b1, 1'b1, 32'h13, 1'b0);
        drive(0, 1'b1, 1'b0, 1'b1, 32'h20, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("t2_hold_valid", 128'(bus.out_valid), 128'd1);
            check("t2_hold_ready", 128'(bus.in_ready),  128'd0);
            check("t2_hold_data",  128'(bus.out_data),  {32'h13, 32'h12, 32'h11, 32'h10});
            check("t2_hold_uuid",  128'(bus.out_uuid),  128'd0);
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        check("t2_ready_open", 128'(bus.in_ready), 128'd1);
        tick();
        bus.in_valid = 1'b0;
        check("t2_emitted_once", 128'(bus.out_valid), 128'd0);
        check("t2_new_tmask",    128'(bus.out_tmask), 128'h1);
        check("t2_new_uuid",     128'(bus.out_uuid),  128'd1);
        check("t2_no_err",       128'(err_pulse),     128'd0);
        send(1, 1'b0, 1'b0, 1'b1, 32'h21, 1'b1);
        send(2, 1'b0, 1'b0, 1'b1, 32'h22, 1'b1);
        send(3, 1'b0, 1'b1, 1'b1, 32'h23, 1'b1);
        check("t2_valid2", 128'(bus.out_valid), 128'd1);
        check("t2_data2",  128'(bus.out_data),  {32'h23, 32'h22, 32'h21, 32'h20});
        tick();
        check("t2_drained", 128'(bus.out_valid), 128'd0);

        // 3: short warp with a masked-off lane, lane 3 never received
        send(0, 1'b1, 1'b0, 1'b1, 32'h30, 1'b0);
        send(1, 1'b0, 1'b0, 1'b0, 32'h31, 1'b0);
        send(2, 1'b0, 1'b1, 1'b1, 32'h32, 1'b0);
        check("t3_valid", 128'(bus.out_valid), 128'd1);
        check("t3_tmask", 128'(bus.out_tmask), 128'h5);
        check("t3_lane0", 128'(bus.out_data[31:0]),  128'h30);
        check("t3_lane2", 128'(bus.out_data[95:64]), 128'h32);
        tick();

        // 4: sop while collecting restarts the warp and flags an error
        send(0, 1'b1, 1'b0, 1'b1, 32'h40, 1'b0);
        send(1, 1'b0, 1'b0, 1'b1, 32'h41, 1'b0);
        send(0, 1'b1, 1'b0, 1'b1, 32'h50, 1'b1);
        check("t4_err",       128'(err_pulse),     128'd1);
        check("t4_no_valid",  128'(bus.out_valid), 128'd0);
        check("t4_tmask_clr", 128'(bus.out_tmask), 128'h1);
        send(1, 1'b0, 1'b0, 1'b1, 32'h51, 1'b1);
        check("t4_err_single", 128'(err_pulse), 128'd0);
        send(2, 1'b0, 1'b0, 1'b1, 32'h52, 1'b1);
        send(3, 1'b0, 1'b1, 1'b1, 32'h53, 1'b1);
        check("t4_valid", 128'(bus.out_valid), 128'd1);
        check("t4_uuid",  128'(bus.out_uuid),  128'd1);
        check("t4_data",  128'(bus.out_data),  {32'h53, 32'h52, 32'h51, 32'h50});
        tick();

        // 5: non-sop in IDLE is dropped; a second one errors again, so state stayed IDLE
        send(1, 1'b0, 1'b0, 1'b1, 32'h60, 1'b0);
        check("t5_err",      128'(err_pulse),     128'd1);
        check("t5_no_valid", 128'(bus.out_valid), 128'd0);
        tick();
        check("t5_err_clear", 128'(err_pulse), 128'd0);
        send(2, 1'b0, 1'b1, 1'b1, 32'h61, 1'b0);
        check("t5_still_idle", 128'(err_pulse),     128'd1);
        check("t5_no_valid2",  128'(bus.out_valid), 128'd0);

        // single-packet warp, then orphan non-sop while draining
        send(0, 1'b1, 1'b1, 1'b1, 32'h70, 1'b0);
        check("sp_valid", 128'(bus.out_valid), 128'd1);
        check("sp_tmask", 128'(bus.out_tmask), 128'h1);
        check("sp_err",   128'(err_pulse),     128'd0);
        send(2, 1'b0, 1'b0, 1'b1, 32'h71, 1'b0);
        check("full_orphan_err",   128'(err_pulse),     128'd1);
        check("full_orphan_valid", 128'(bus.out_valid), 128'd0);

        // repeated pid overwrites silently
        send(0, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0);
        send(0, 1'b0, 1'b0, 1'b1, 32'h81, 1'b0);
        check("rep_no_err", 128'(err_pulse), 128'd0);
        send(1, 1'b0, 1'b1, 1'b1, 32'h82, 1'b0);
        check("rep_tmask", 128'(bus.out_tmask), 128'h3);
        check("rep_lane0", 128'(bus.out_data[31:0]), 128'h81);
        tick();

        // 6: reset mid-warp drops the partial warp
        send(0, 1'b1, 1'b0, 1'b1, 32'h90, 1'b0);
        send(1, 1'b0, 1'b0, 1'b1, 32'h91, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_valid", 128'(bus.out_valid), 128'd0);
        check("t6_tmask", 128'(bus.out_tmask), 128'd0);
        check("t6_err",   128'(err_pulse),     128'd0);
        send(2, 1'b0, 1'b1, 1'b1, 32'h92, 1'b0);
        check("t6_orphan_err",   128'(err_pulse),     128'd1);
        check("t6_orphan_valid", 128'(bus.out_valid), 128'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
